// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue_if
// Purpose  : Fetch-stage bundle: PC register, instruction memory and decode.
// Revision : 1.0
// ============================================================================
interface instr_fetch_queue_if #(
    parameter int XLEN = 32
);
    // PC register side
    logic [XLEN-1:0] iPC;
    logic            iRedirect;
    logic            oPCAdv;
    // Instruction memory side
    logic            oMemReq;
    logic [XLEN-1:0] oMemAddr;
    logic            iMemGnt;
    logic            iMemRValid;
    logic [XLEN-1:0] iMemRData;
    // Decode side
    logic            oInstrValid;
    logic [XLEN-1:0] oInstr;
    logic [XLEN-1:0] oInstrPC;
    logic            iDecodeReady;

    modport slave (
        input  iPC, iRedirect, iMemGnt, iMemRValid, iMemRData, iDecodeReady,
        output oPCAdv, oMemReq, oMemAddr, oInstrValid, oInstr, oInstrPC
    );

    modport master (
        output iPC, iRedirect, iMemGnt, iMemRValid, iMemRData, iDecodeReady,
        input  oPCAdv, oMemReq, oMemAddr, oInstrValid, oInstr, oInstrPC
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Single-outstanding instruction fetcher feeding a DEPTH-entry queue.
// Revision : 1.0
// ============================================================================
module instr_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  wire logic           iClk,
    input  wire logic           iRst,
    instr_fetch_queue_if.slave  bus
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_issued_pc;
    logic [XLEN-1:0]     r_instr_q [DEPTH];
    logic [XLEN-1:0]     r_pc_q    [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_not_full;
    logic w_nonempty;
    logic w_req;
    logic w_grant;
    logic w_push;
    logic w_valid;
    logic w_pop;

    assign w_not_full = (r_count < c_CNT_W'(DEPTH));
    assign w_nonempty = (r_count != '0);

    // Request is independent of the grant; reset gates it so nothing leaks
    // out while the rest of the state is being forced to zero.
    assign w_req   = !iRst && (r_state == S_IDLE) && !bus.iRedirect && w_not_full;
    assign w_grant = w_req && bus.iMemGnt;
    assign w_push  = (r_state == S_WAIT) && bus.iMemRValid && !bus.iRedirect;
    assign w_valid = w_nonempty && !bus.iRedirect;
    assign w_pop   = w_valid && bus.iDecodeReady;

    assign bus.oMemReq     = w_req;
    assign bus.oMemAddr    = {bus.iPC[XLEN-1:2], 2'b00};
    assign bus.oPCAdv      = w_grant;
    assign bus.oInstrValid = w_valid;
    assign bus.oInstr      = w_nonempty ? r_instr_q[r_rd_ptr] : '0;
    assign bus.oInstrPC    = w_nonempty ? r_pc_q[r_rd_ptr]    : '0;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= S_IDLE;
            r_issued_pc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_issued_pc <= bus.iPC;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.iMemRValid) begin
                        r_state <= S_IDLE;
                    end else if (bus.iRedirect) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.iMemRValid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A redirect wins over push/pop: both are already suppressed that cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.iRedirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux masks it whenever count is zero.
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= bus.iMemRData;
            r_pc_q[r_wr_ptr]    <= r_issued_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Directed bench with PC-register/memory models and a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;
    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_DROP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Stimulus controls
    logic        redir  = 1'b0;
    logic        dready = 1'b1;
    logic        gnt_en = 1'b1;
    logic [31:0] target = '0;
    int          lat    = 1;

    // PC register, memory and fetch-unit reference models
    logic [31:0] pc_reg    = '0;
    int          m_state   = S_IDLE;
    logic [63:0] exp_q[$];
    logic        inflight  = 1'b0;
    int          rem       = 0;
    logic [31:0] in_data   = '0;
    logic [31:0] issued_pc = '0;

    // DUT-observed grant bookkeeping
    int          dut_gnts      = 0;
    logic [31:0] last_gnt_addr = '0;
    int          last_gnt_cyc  = -1;
    logic        got_gnt       = 1'b0;

    int          gc[$];
    logic [31:0] ga[$];
    int          n0;
    int          raise_cyc;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cyc();
        logic        rv;
        logic        exp_req;
        logic        exp_valid;
        logic        gnt;
        logic [63:0] head;
        rv                = inflight && (rem == 1);
        bus.iPC           = pc_reg;
        bus.iRedirect     = redir;
        bus.iDecodeReady  = dready;
        bus.iMemGnt       = gnt_en;
        bus.iMemRValid    = rv;
        bus.iMemRData     = rv ? in_data : $urandom();
        #2;
        exp_req   = (m_state == S_IDLE) && !redir && (exp_q.size() < DEPTH);
        exp_valid = (exp_q.size() != 0) && !redir;
        gnt       = exp_req && gnt_en;
        chk("mem_req",     32'(bus.oMemReq),     32'(exp_req));
        chk("pc_adv",      32'(bus.oPCAdv),      32'(gnt));
        chk("instr_valid", 32'(bus.oInstrValid), 32'(exp_valid));
        if (exp_req) chk("mem_addr", bus.oMemAddr, {pc_reg[31:2], 2'b00});
        if (exp_valid) begin
            head = exp_q[0];
            chk("instr",    bus.oInstr,   head[63:32]);
            chk("instr_pc", bus.oInstrPC, head[31:0]);
        end
        got_gnt = bus.oPCAdv;
        if (bus.oPCAdv === 1'b1) begin
            dut_gnts++;
            last_gnt_addr = bus.oMemAddr;
            last_gnt_cyc  = cyc_n;
        end
        @(posedge clk);
        if (redir) exp_q.delete();
        else if (exp_valid && dready) void'(exp_q.pop_front());
        case (m_state)
            S_IDLE: if (gnt) m_state = S_WAIT;
            S_WAIT: begin
                if (rv) begin
                    if (!redir) exp_q.push_back({in_data, issued_pc});
                    m_state = S_IDLE;
                end else if (redir) begin
                    m_state = S_DROP;
                end
            end
            S_DROP: if (rv) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
        if (inflight) rem--;
        if (rv) inflight = 1'b0;
        if (gnt) begin
            inflight  = 1'b1;
            rem       = lat;
            in_data   = mk_instr({pc_reg[31:2], 2'b00});
            issued_pc = pc_reg;
        end
        pc_reg = redir ? target : (gnt ? pc_reg + 32'd4 : pc_reg);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic wait_grant(input string tag);
        int base;
        base = dut_gnts;
        for (int k = 0; k < 20 && dut_gnts == base; k++) cyc();
        chk(tag, 32'(dut_gnts > base), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(bus.oMemReq),     32'd0);
        chk({tag, "_adv"},   32'(bus.oPCAdv),      32'd0);
        chk({tag, "_valid"}, 32'(bus.oInstrValid), 32'd0);
        chk({tag, "_instr"}, bus.oInstr,           32'd0);
        chk({tag, "_pc"},    bus.oInstrPC,         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iPC          = '0;
        bus.iRedirect    = 1'b0;
        bus.iDecodeReady = 1'b1;
        bus.iMemGnt      = 1'b1;
        bus.iMemRValid   = 1'b0;
        bus.iMemRData    = '0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch, 1-cycle memory, decode always ready
        lat = 1; gnt_en = 1'b1; dready = 1'b1; redir = 1'b0;
        repeat (6) begin
            cyc();
            if (got_gnt) begin
                gc.push_back(last_gnt_cyc);
                ga.push_back(last_gnt_addr);
            end
        end
        chk("seq_ngrants", gc.size(), 32'd3);
        if (gc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("seq_gnt_cycle", gc[i], 32'(2 * i));
                chk("seq_gnt_addr",  ga[i], 32'(4 * i));
            end
        end

        // Hold an ungranted request (address must stay put), drain the queue
        gnt_en = 1'b0;
        repeat (3) cyc();

        // Decode stalled: exactly DEPTH fetches, then requests stop
        gnt_en = 1'b1; dready = 1'b0;
        n0 = dut_gnts;
        repeat (10) cyc();
        chk("stall_fill", dut_gnts - n0, DEPTH);
        chk("stall_req_low", 32'(bus.oMemReq), 32'd0);

        // Release decode: fetching resumes one cycle after the first pop
        dready = 1'b1;
        raise_cyc = cyc_n;
        n0 = dut_gnts;
        for (int k = 0; k < 10 && dut_gnts == n0; k++) cyc();
        chk("resume_cycle", last_gnt_cyc, raise_cyc + 1);
        repeat (8) cyc();

        // Redirect one cycle after grant with 3-cycle memory, unaligned target
        lat = 3;
        wait_grant("redir_wait_grant");
        redir = 1'b1; target = 32'h0000_0102;
        cyc();
        redir = 1'b0;
        wait_grant("redir_next_grant");
        chk("redir_target_addr", last_gnt_addr, 32'h0000_0100);
        repeat (8) cyc();

        // Redirect coincident with a response
        lat = 2;
        wait_grant("coinc_grant");
        cyc();
        redir = 1'b1; target = 32'h0000_0200;
        cyc();
        redir = 1'b0;
        chk("coinc_empty", 32'(bus.oInstrValid), 32'd0);

        // Redirect with a pending, ungranted request
        gnt_en = 1'b0;
        repeat (2) cyc();
        gnt_en = 1'b1; redir = 1'b1; target = 32'h0000_0300;
        cyc();
        redir = 1'b0;
        wait_grant("pend_next_grant");
        chk("pend_target_addr", last_gnt_addr, 32'h0000_0300);
        repeat (6) cyc();

        // Wrap-around: 10 fetches with random decode back-pressure
        lat = 1;
        n0 = dut_gnts;
        for (int k = 0; k < 200 && (dut_gnts - n0) < 10; k++) begin
            dready = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("wrap_fetches", dut_gnts - n0, 32'd10);
        gnt_en = 1'b0; dready = 1'b1;
        repeat (6) cyc();
        chk("wrap_drained", 32'(bus.oInstrValid), 32'd0);

        // Asynchronous reset in WAIT while the response is on the bus
        gnt_en = 1'b1; lat = 2;
        wait_grant("rst_grant");
        cyc();
        bus.iPC          = pc_reg;
        bus.iRedirect    = 1'b0;
        bus.iMemGnt      = 1'b1;
        bus.iDecodeReady = 1'b1;
        bus.iMemRValid   = 1'b1;
        bus.iMemRData    = in_data;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_state  = S_IDLE;
        exp_q.delete();
        inflight = 1'b0;
        rem      = 0;
        pc_reg   = '0;
        wait_grant("post_rst_grant");
        chk("post_rst_addr", last_gnt_addr, 32'h0000_0000);
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
